// File: rtl/ternary_matvec_pkg.sv
// ternary_matvec_pkg
// Shared types and helpers for the ternary matrix-vector stage.
//   - VEC_D          : default vector length / matrix dimension
//   - fixed_point_t  : signed Q8.8 activation format
//   - ternary_t      : 2-bit weight code (01 = +1, 11 = -1, 00 / 10 = 0)
//   - saturate_fixed : clamp a wide signed accumulator to fixed_point_t
//   - StIdle / StRun : FSM state encodings
package ternary_matvec_pkg;

    localparam int unsigned VEC_D = 8;
    localparam int unsigned FP_W  = 16;

    typedef logic signed [FP_W-1:0] fixed_point_t;
    typedef logic [1:0]             ternary_t;

    localparam ternary_t TERN_ZERO = 2'b00;
    localparam ternary_t TERN_POS  = 2'b01;
    localparam ternary_t TERN_NEG  = 2'b11;

    localparam fixed_point_t FP_MAX = {1'b0, {(FP_W-1){1'b1}}};
    localparam fixed_point_t FP_MIN = {1'b1, {(FP_W-1){1'b0}}};

    // Accumulators are sign-extended to this width before saturation.
    localparam int unsigned SAT_IN_W = 32;

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    function automatic fixed_point_t saturate_fixed(input logic signed [SAT_IN_W-1:0] acc);
        logic signed [SAT_IN_W-1:0] hi;
        logic signed [SAT_IN_W-1:0] lo;
        hi = $signed({{(SAT_IN_W-FP_W){1'b0}}, FP_MAX});
        lo = $signed({{(SAT_IN_W-FP_W){1'b1}}, FP_MIN});
        if (acc > hi) begin
            return FP_MAX;
        end else if (acc < lo) begin
            return FP_MIN;
        end else begin
            return acc[FP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/ternary_matvec_mac.sv
// ternary_matvec_mac
// Ternary multiply-accumulate: selects +x, -x or 0 from the weight code and
// adds it to a registered accumulator.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : load zero into the accumulator (has priority over en_i)
//   en_i          : load sum_o into the accumulator
//   x_i           : activation sample (fixed_point_t bits)
//   w_i           : ternary weight code
//   sum_o         : acc_q + term, used directly for the last-column writeback
module ternary_matvec_mac
    import ternary_matvec_pkg::*;
#(
    parameter int unsigned ACC_W = FP_W + 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [FP_W-1:0]  x_i,
    input  logic [1:0]       w_i,
    output logic [ACC_W-1:0] sum_o
);

    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    assign x_ext = {{(ACC_W-FP_W){x_i[FP_W-1]}}, x_i};

    // Negating the most-negative x is exact because ACC_W > FP_W.
    always_comb begin
        term = '0;
        case (ternary_t'(w_i))
            TERN_POS:  term = x_ext;
            TERN_NEG:  term = -x_ext;
            TERN_ZERO: term = '0;
            default:   term = '0;  // reserved code reads as zero
        endcase
    end

    assign sum   = acc_q + term;
    assign sum_o = sum;

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ternary_matvec.sv
// ternary_matvec
// Computes out[j] = sum_i W[j][i] * x[i] with a ternary D x D weight matrix,
// one weight per cycle, row-major. Each row's saturated result is written on
// the cycle that consumes its last column.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   in_start_i / in_ready_o  : start handshake (accepted only while idle)
//   vector_r_addr_o / _data_i: activation read port (combinational data)
//   matrix_r_row_o / _col_o  : weight read address, matrix_r_data_i returns W
//   out_w_en_o/_addr_o/_data_o: output buffer write port
//   out_done_o               : one-cycle pulse after the final row is written
module ternary_matvec
    import ternary_matvec_pkg::*;
#(
    parameter int unsigned D     = VEC_D,
    parameter int unsigned ACC_W = FP_W + $clog2(D) + 1,
    parameter int unsigned AW    = (D > 1) ? $clog2(D) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_start_i,
    output logic            in_ready_o,
    output logic [AW-1:0]   vector_r_addr_o,
    input  logic [FP_W-1:0] vector_r_data_i,
    output logic [AW-1:0]   matrix_r_row_o,
    output logic [AW-1:0]   matrix_r_col_o,
    input  logic [1:0]      matrix_r_data_i,
    output logic            out_w_en_o,
    output logic [AW-1:0]   out_w_addr_o,
    output logic [FP_W-1:0] out_w_data_o,
    output logic            out_done_o
);

    logic          state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] col_q, col_d;
    logic          done_q, done_d;

    logic          last_col, last_row;
    logic          mac_clear, mac_en;
    logic          write;
    logic signed [ACC_W-1:0] sum;

    assign last_col = (col_q == AW'(D - 1));
    assign last_row = (row_q == AW'(D - 1));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        done_d    = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            StIdle: begin
                mac_clear = 1'b1;
                if (in_start_i) begin
                    state_d = StRun;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            StRun: begin
                if (last_col) begin
                    // Row is written this cycle from sum; start the next row clean.
                    mac_clear = 1'b1;
                    col_d     = '0;
                    if (last_row) begin
                        state_d = StIdle;
                        row_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + AW'(1);
                    end
                end else begin
                    mac_en = 1'b1;
                    col_d  = col_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            done_q  <= done_d;
        end
    end

    ternary_matvec_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (mac_clear),
        .en_i    (mac_en),
        .x_i     (vector_r_data_i),
        .w_i     (matrix_r_data_i),
        .sum_o   (sum)
    );

    assign write = (state_q == StRun) && last_col;

    assign in_ready_o      = (state_q == StIdle);
    assign vector_r_addr_o = col_q;
    assign matrix_r_row_o  = row_q;
    assign matrix_r_col_o  = col_q;
    assign out_w_en_o      = write;
    assign out_w_addr_o    = row_q;
    assign out_w_data_o    = write ? saturate_fixed(SAT_IN_W'(sum)) : '0;
    assign out_done_o      = done_q;

endmodule
